fft_spectrum_accum: RTL and testbench
=====================================

# fft_spectrum_accum

Parametrised power-spectrum post-processor that sits directly after the FFT core's AXI-Stream output on the calculation clock. It converts each complex bin to power, averages 2^k consecutive frames in on-chip RAM, and tracks the peak bin. It exposes the averaged spectrum through a synchronous read port with a done flag. It replaces the fixed single-frame magnitude path: averaging, peak search, tlast checking and restart are new behaviour.

## Interface
- DW, 16: signed width of each of re/im.
- LOG2N, 15: log2 of FFT points; N = 2^LOG2N.
- AVG_MAX, 4: maximum log2 of the averaged frame count.
- SKIP_DC, 1: 1 excludes bin 0 from the peak search.
- PW (local), 2*DW+1: power width.
- AW (local), PW+AVG_MAX: accumulator/RAM width.
- clk_Cal  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- start_sig  in  1  one-cycle pulse that arms or restarts a capture.
- avg_log2  in  3  frames averaged = 2^avg_log2. Sampled at start_sig. Values above AVG_MAX are clamped to AVG_MAX.
- s_tdata  in  2*DW  {im, re}, two's complement.
- s_tvalid  in  1  input beat valid.
- s_tlast  in  1  frame end marker from the FFT core.
- s_tready  out  1  high only in ACCUM.
- rd_addr  in  LOG2N  bin to read.
- rd_data  out  PW  averaged power, (sum >> avg_log2) truncated to PW bits.
- busy  out  1  high in ACCUM and FLUSH.
- done  out  1  sticky; set when averaging completes, cleared by start_sig.
- peak_bin  out  LOG2N  index of the maximum averaged bin.
- peak_val  out  PW  value at peak_bin.
- tlast_err  out  1  sticky; set on any tlast mismatch, cleared by start_sig.

## Operation
- The FSM has three states: IDLE, ACCUM and FLUSH. Reset enters IDLE.
- IDLE -> ACCUM on start_sig. On that transition: bin counter = 0, frame counter = 0, peak_val = 0, peak_bin = 0, done = 0, tlast_err = 0, and avg_log2 is latched.
- In ACCUM, each accepted beat (s_tvalid & s_tready) gets power p = re*re + im*im (unsigned PW bits) and is written to RAM[bin]:
  - first frame: RAM[bin] = p;
  - later frames: RAM[bin] = RAM[bin] + p.
  - No separate clear pass is needed.
- Bin counter increments per beat and wraps N-1 -> 0. The frame counter increments on that wrap. The frame boundary is always bin N-1; s_tlast does not define it.
- tlast checking: tlast_err is set if s_tlast = 1 on a bin other than N-1, or if s_tlast = 0 on bin N-1.
- When the beat at bin N-1 of the last frame (frame 2^avg_log2 - 1) is accepted, the FSM moves ACCUM -> FLUSH and drops s_tready.
- FLUSH -> IDLE once the pipeline is empty. done is set on that same edge.
- Peak search runs only during last-frame writes, on the averaged value (sum >> avg_log2):
  - replace the peak only if the value is strictly greater, so ties keep the lowest bin;
  - bin 0 is ignored when SKIP_DC = 1.
- start_sig in ACCUM or FLUSH aborts and restarts: in-flight pipeline writes are squashed and the ACCUM entry actions are repeated. start_sig in the same cycle as a final beat: start_sig wins, done stays 0.
- RAM is a single write port plus a single read port, and is inferable as block RAM.
- rd_data is valid at any time. Content is undefined while busy or before the first done.

## Timing
- Reset values: s_tready 0, busy 0, done 0, tlast_err 0, peak_bin 0, peak_val 0, rd_data 0.
- s_tready rises the cycle after start_sig and sustains 1 beat/cycle with no bubbles.
- Write pipeline is 3 stages:
  - t+1: register the input beat and issue the RAM read of the bin;
  - t+2: squares summed, RAM data returned;
  - t+3: add and write.
- Back-to-back beats hit distinct bins; there is no read-after-write hazard for N >= 4.
- LOG2N >= 2 is required.
- done and the final peak_* values are visible at t+4 after the final beat at edge t.
- Read port: rd_addr sampled at edge e, rd_data valid after edge e+1. A same-cycle read and write of one address returns the old value.
- tlast_err is updated the cycle after the offending beat.

## Test plan
- LOG2N=3, avg_log2=0, frame re=bin, im=0 -> after done, rd_data[b] = b*b for b=0..7; peak_bin=7, peak_val=49; done 4 cycles after the last beat.
- avg_log2=2, four frames bin 3 = {re=4, im=0}, {re=0, im=4}, {re=2, im=0}, {re=0, im=6}, all other bins 0 -> rd_data[3] = (16+16+4+36)>>2 = 18; peak_bin=3.
- Random s_tvalid gaps (30% idle), 2 frames -> results identical to gapless run; s_tready low in IDLE/FLUSH.
- tlast on bin 5 of an 8-point frame, and tlast missing on bin 7 -> tlast_err=1 both cases, results still computed, cleared by next start_sig.
- Ties: bins 2 and 6 both 25, SKIP_DC=1, bin 0 = 100 -> peak_bin=2, peak_val=25.
- start_sig mid-frame-2 of 4, then full 4 frames; plus rst_n low mid-ACCUM -> restart gives clean averages with no stale data; reset returns all outputs to reset values immediately.

Source files
------------

// File: rtl/fft_spectrum_accum.sv
// Power-spectrum post-processor: |X|^2 per FFT bin, 2^k-frame averaging in RAM,
// peak-bin tracking and a synchronous read-back port, all on clk_Cal.
module fft_spectrum_accum #(
  parameter  int DW      = 16,
  parameter  int LOG2N   = 15,
  parameter  int AVG_MAX = 4,
  parameter  int SKIP_DC = 1,
  localparam int PW      = 2*DW+1,
  localparam int AW      = PW+AVG_MAX
) (
  input  logic             clk_Cal,
  input  logic             rst_n,
  input  logic             start_sig,
  input  logic [2:0]       avg_log2,
  input  logic [2*DW-1:0]  s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  input  logic [LOG2N-1:0] rd_addr,
  output logic [PW-1:0]    rd_data,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] peak_bin,
  output logic [PW-1:0]    peak_val,
  output logic             tlast_err
);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  typedef struct packed {
    logic [LOG2N-1:0] bin;
    logic [DW-1:0]    re;
    logic [DW-1:0]    im;
    logic             first;
    logic             last;
  } beat_t;

  state_t               state;
  logic [2:0]           avg_lat;
  logic [LOG2N-1:0]     bin_cnt;
  logic [AVG_MAX-1:0]   frame_cnt;
  logic [STAGES:0]      vld_pipe;
  beat_t                s0, s1;
  logic [LOG2N-1:0]     s2_bin;
  logic                 s2_first, s2_last;
  logic [PW-1:0]        s2_pwr;
  logic [AW-1:0]        s2_old;
  logic [AW-1:0]        ram_q;
  logic [AW-1:0]        ram [0:(1<<LOG2N)-1];

  logic                 accept, last_bin, last_frame, wr_en, dc_skip, peak_hit;
  logic [2:0]           avg_clamp;
  logic [AVG_MAX-1:0]   last_idx;
  logic [LOG2N-1:0]     rd_sel;
  logic signed [2*DW-1:0] re_x, im_x, re_sq, im_sq;
  logic [PW-1:0]        pwr, new_avg;
  logic [AW-1:0]        new_sum;

  // A beat arriving with start_sig is dropped: the restart owns that cycle.
  assign accept     = s_tvalid & s_tready & ~start_sig;
  assign last_bin   = &bin_cnt;
  assign last_idx   = ~({AVG_MAX{1'b1}} << avg_lat);
  assign last_frame = (frame_cnt == last_idx);
  assign avg_clamp  = (32'(avg_log2) > AVG_MAX) ? 3'(AVG_MAX) : avg_log2;

  // Squares are exact in 2*DW bits, including (-2^(DW-1))^2.
  assign re_x  = {{DW{s1.re[DW-1]}}, s1.re};
  assign im_x  = {{DW{s1.im[DW-1]}}, s1.im};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  assign pwr   = {1'b0, re_sq} + {1'b0, im_sq};

  assign new_sum  = s2_first ? AW'(s2_pwr) : s2_old + AW'(s2_pwr);
  assign new_avg  = PW'(new_sum >> avg_lat);
  assign wr_en    = vld_pipe[STAGES] & ~start_sig;
  assign dc_skip  = (SKIP_DC != 0) && (s2_bin == '0);
  assign peak_hit = wr_en & s2_last & ~dc_skip & (new_avg > peak_val);

  // The single RAM read port serves the accumulate path while busy, rd_addr otherwise.
  assign rd_sel = (state == IDLE) ? rd_addr : s0.bin;

  always_ff @(posedge clk_Cal) begin
    if (accept) begin
      s0.bin   <= bin_cnt;
      s0.re    <= s_tdata[DW-1:0];
      s0.im    <= s_tdata[2*DW-1:DW];
      s0.first <= (frame_cnt == '0);
      s0.last  <= last_frame;
    end
    s1       <= s0;
    s2_bin   <= s1.bin;
    s2_first <= s1.first;
    s2_last  <= s1.last;
    s2_pwr   <= pwr;
    s2_old   <= ram_q;
    ram_q    <= ram[rd_sel];
    if (wr_en) ram[s2_bin] <= new_sum;
  end

  always_ff @(posedge clk_Cal or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      avg_lat   <= '0;
      bin_cnt   <= '0;
      frame_cnt <= '0;
      vld_pipe  <= '0;
      s_tready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tlast_err <= 1'b0;
      peak_bin  <= '0;
      peak_val  <= '0;
      rd_data   <= '0;
    end else begin
      rd_data  <= PW'(ram_q >> avg_lat);
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
      if (start_sig) begin
        state     <= ACCUM;
        avg_lat   <= avg_clamp;
        bin_cnt   <= '0;
        frame_cnt <= '0;
        vld_pipe  <= '0;
        s_tready  <= 1'b1;
        busy      <= 1'b1;
        done      <= 1'b0;
        tlast_err <= 1'b0;
        peak_bin  <= '0;
        peak_val  <= '0;
      end else begin
        if (peak_hit) begin
          peak_val <= new_avg;
          peak_bin <= s2_bin;
        end
        case (state)
          ACCUM: if (accept) begin
            bin_cnt <= bin_cnt + 1'b1;
            if (s_tlast != last_bin) tlast_err <= 1'b1;
            if (last_bin) begin
              frame_cnt <= frame_cnt + 1'b1;
              if (last_frame) begin
                state    <= FLUSH;
                s_tready <= 1'b0;
              end
            end
          end
          FLUSH: if (vld_pipe == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fft_spectrum_accum.sv
// Randomized bench for fft_spectrum_accum (8-point frames) against a
// frame-array reference model of the averaged spectrum and peak.
module tb_fft_spectrum_accum;
  localparam int DW = 16, LOG2N = 3, AVG_MAX = 4, SKIP_DC = 1, N = 8, PW = 2*DW+1;

  logic             clk_Cal = 0, rst_n = 0, start_sig = 0;
  logic [2:0]       avg_log2 = 0;
  logic [2*DW-1:0]  s_tdata = 0;
  logic             s_tvalid = 0, s_tlast = 0;
  logic             s_tready, busy, done, tlast_err;
  logic [LOG2N-1:0] rd_addr = 0, peak_bin;
  logic [PW-1:0]    rd_data, peak_val;

  int     n_checks = 0, n_fail = 0;
  int     fr_re[16][N], fr_im[16][N];
  longint exp_avg[N];
  longint exp_pk_val;
  int     exp_pk_bin;

  always #5 clk_Cal = ~clk_Cal;

  fft_spectrum_accum #(.DW(DW), .LOG2N(LOG2N), .AVG_MAX(AVG_MAX), .SKIP_DC(SKIP_DC)) dut (
    .clk_Cal(clk_Cal), .rst_n(rst_n), .start_sig(start_sig), .avg_log2(avg_log2),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .peak_bin(peak_bin), .peak_val(peak_val), .tlast_err(tlast_err));

  // Reference: average of per-frame powers, then first strictly-largest bin.
  function automatic void model(input int a_in);
    int a;
    longint s;
    a = (a_in > AVG_MAX) ? AVG_MAX : a_in;
    exp_pk_bin = 0;
    exp_pk_val = 0;
    for (int b = 0; b < N; b++) begin
      s = 0;
      for (int f = 0; f < (1 << a); f++)
        s += longint'(fr_re[f][b]) * fr_re[f][b] + longint'(fr_im[f][b]) * fr_im[f][b];
      exp_avg[b] = s >> a;
      if (b >= SKIP_DC && exp_avg[b] > exp_pk_val) begin
        exp_pk_val = exp_avg[b];
        exp_pk_bin = b;
      end
    end
  endfunction

  function automatic void fill_random();
    for (int f = 0; f < 16; f++)
      for (int b = 0; b < N; b++) begin
        fr_re[f][b] = int'($urandom_range(0, 65535)) - 32768;
        fr_im[f][b] = int'($urandom_range(0, 65535)) - 32768;
      end
  endfunction

  function automatic void fill_zero();
    for (int f = 0; f < 16; f++)
      for (int b = 0; b < N; b++) begin
        fr_re[f][b] = 0;
        fr_im[f][b] = 0;
      end
  endfunction

  task automatic do_start(input int a);
    @(negedge clk_Cal);
    start_sig = 1; avg_log2 = 3'(a); s_tvalid = 0;
    @(posedge clk_Cal); #1;
    start_sig = 0;
  endtask

  task automatic send_beat(input int re, input int im, input bit tl);
    @(negedge clk_Cal);
    s_tvalid = 1; s_tdata = {DW'(im), DW'(re)}; s_tlast = tl;
    for (int k = 0; k < 20 && !s_tready; k++) @(negedge clk_Cal);
    n_checks++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL beat_accept: s_tready=%0b required 1", s_tready);
    end
    @(posedge clk_Cal); #1;
    s_tvalid = 0;
  endtask

  task automatic idle_cycle();
    @(negedge clk_Cal);
    s_tvalid = 0; s_tdata = $urandom;
    @(posedge clk_Cal); #1;
  endtask

  task automatic read_bin(input int b, output logic [PW-1:0] d);
    @(negedge clk_Cal);
    rd_addr = LOG2N'(b);
    @(posedge clk_Cal);
    @(posedge clk_Cal); #1;
    d = rd_data;
  endtask

  // bad: 0 clean, 1 early tlast on bin 5 of frame 0, 2 missing tlast on bin 7 of frame 0
  task automatic run_capture(input int a_in, input int gap_pct, input int bad,
                             output int lat, output bit fl_ok);
    int a;
    bit tl;
    a = (a_in > AVG_MAX) ? AVG_MAX : a_in;
    do_start(a_in);
    for (int f = 0; f < (1 << a); f++)
      for (int b = 0; b < N; b++) begin
        if (int'($urandom_range(0, 99)) < gap_pct) idle_cycle();
        tl = (b == N-1);
        if (bad == 1 && f == 0 && b == 5) tl = 1;
        if (bad == 2 && f == 0 && b == N-1) tl = 0;
        send_beat(fr_re[f][b], fr_im[f][b], tl);
      end
    lat = -1;
    fl_ok = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_Cal); #1;
      if (i == 1) fl_ok = busy && !s_tready;
      if (done) begin lat = i; break; end
    end
    n_checks++;
    if (lat < 0) begin
      n_fail++;
      $display("FAIL done_timeout: done=%0b required 1 within 20 cycles", done);
    end
  endtask

  task automatic check_results(input string name);
    logic [PW-1:0] d;
    for (int b = 0; b < N; b++) begin
      read_bin(b, d);
      n_checks++;
      if (d !== PW'(exp_avg[b])) begin
        n_fail++;
        $display("FAIL %s rd_data[%0d]: got %0d required %0d", name, b, d, exp_avg[b]);
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({s_tready, busy, done, tlast_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000", {s_tready, busy, done, tlast_err});
    end
    n_checks++;
    if (peak_bin !== '0 || peak_val !== '0) begin
      n_fail++;
      $display("FAIL reset_peak: got bin %0d val %0d required 0 0", peak_bin, peak_val);
    end
    n_checks++;
    if (rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %0d required 0", rd_data);
    end
  endtask

  task automatic test_ramp();
    int lat;
    bit fl;
    logic [PW-1:0] d;
    fill_zero();
    for (int b = 0; b < N; b++) fr_re[0][b] = b;
    do_start(0);
    n_checks++;
    if (s_tready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_ready_after_start: tready %0b busy %0b required 1 1", s_tready, busy);
    end
    for (int b = 0; b < N; b++) send_beat(b, 0, b == N-1);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_Cal); #1;
      if (done) begin lat = i; break; end
    end
    n_checks++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL ramp_done_latency: got %0d required 4", lat);
    end
    n_checks++;
    if (peak_bin !== 3'd7 || peak_val !== PW'(49)) begin
      n_fail++;
      $display("FAIL ramp_peak: got bin %0d val %0d required 7 49", peak_bin, peak_val);
    end
    for (int b = 0; b < N; b++) begin
      read_bin(b, d);
      n_checks++;
      if (d !== PW'(b*b)) begin
        n_fail++;
        $display("FAIL ramp rd_data[%0d]: got %0d required %0d", b, d, b*b);
      end
    end
    fl = 0;
  endtask

  task automatic test_avg4();
    int lat;
    bit fl;
    fill_zero();
    fr_re[0][3] = 4; fr_im[1][3] = 4; fr_re[2][3] = 2; fr_im[3][3] = 6;
    run_capture(2, 0, 0, lat, fl);
    model(2);
    n_checks++;
    if (peak_bin !== 3'd3 || peak_val !== PW'(18)) begin
      n_fail++;
      $display("FAIL avg4_peak: got bin %0d val %0d required 3 18", peak_bin, peak_val);
    end
    check_results("avg4");
  endtask

  task automatic test_gaps();
    int lat;
    bit fl;
    fill_random();
    model(1);
    n_checks++;
    if (s_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_idle_tready: got %0b required 0", s_tready);
    end
    run_capture(1, 0, 0, lat, fl);
    check_results("gapless");
    run_capture(1, 30, 0, lat, fl);
    n_checks++;
    if (!fl) begin
      n_fail++;
      $display("FAIL gaps_flush_tready: tready %0b busy %0b required 0 1", s_tready, busy);
    end
    n_checks++;
    if (peak_bin !== LOG2N'(exp_pk_bin) || peak_val !== PW'(exp_pk_val)) begin
      n_fail++;
      $display("FAIL gaps_peak: got bin %0d val %0d required %0d %0d", peak_bin, peak_val, exp_pk_bin, exp_pk_val);
    end
    check_results("gapped");
  endtask

  task automatic test_tlast();
    int lat;
    bit fl;
    fill_random();
    model(0);
    for (int k = 1; k <= 2; k++) begin
      run_capture(0, 0, k, lat, fl);
      n_checks++;
      if (tlast_err !== 1'b1) begin
        n_fail++;
        $display("FAIL tlast_err_case%0d: got %0b required 1", k, tlast_err);
      end
      check_results("tlast");
      do_start(0);
      n_checks++;
      if (tlast_err !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL tlast_clear_case%0d: err %0b done %0b required 0 0", k, tlast_err, done);
      end
    end
  endtask

  task automatic test_ties();
    int lat;
    bit fl;
    fill_zero();
    fr_re[0][0] = 10; fr_re[0][1] = 1; fr_re[0][2] = 3; fr_im[0][2] = 4;
    fr_re[0][3] = 2;  fr_re[0][5] = 4; fr_re[0][6] = 5; fr_re[0][7] = 1; fr_im[0][7] = 1;
    run_capture(0, 0, 0, lat, fl);
    n_checks++;
    if (peak_bin !== 3'd2 || peak_val !== PW'(25)) begin
      n_fail++;
      $display("FAIL ties_peak: got bin %0d val %0d required 2 25", peak_bin, peak_val);
    end
  endtask

  task automatic test_restart();
    int lat;
    bit fl;
    do_start(2);
    for (int b = 0; b < N + 3; b++) send_beat(int'($urandom_range(0, 9000)), 77, (b % N) == N-1);
    fill_random();
    model(2);
    run_capture(2, 0, 0, lat, fl);
    check_results("restart");
    // final beat coinciding with start_sig: the restart wins
    do_start(0);
    for (int b = 0; b < N-1; b++) send_beat(b, b, 0);
    @(negedge clk_Cal);
    s_tvalid = 1; s_tdata = {DW'(0), DW'(7)}; s_tlast = 1; start_sig = 1;
    @(posedge clk_Cal); #1;
    start_sig = 0; s_tvalid = 0;
    repeat (6) @(posedge clk_Cal);
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_vs_final: done %0b busy %0b tready %0b required 0 1 1", done, busy, s_tready);
    end
    // asynchronous reset in the middle of a capture
    for (int b = 0; b < 5; b++) send_beat(b + 100, 3, 0);
    @(negedge clk_Cal);
    rst_n = 0;
    #1;
    n_checks++;
    if ({s_tready, busy, done, tlast_err} !== 4'b0 || peak_bin !== '0 || peak_val !== '0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset: flags %b bin %0d val %0d rd %0d required all 0",
               {s_tready, busy, done, tlast_err}, peak_bin, peak_val, rd_data);
    end
    @(negedge clk_Cal);
    rst_n = 1;
    fill_random();
    model(2);
    run_capture(2, 0, 0, lat, fl);
    n_checks++;
    if (peak_bin !== LOG2N'(exp_pk_bin) || peak_val !== PW'(exp_pk_val)) begin
      n_fail++;
      $display("FAIL post_reset_peak: got bin %0d val %0d required %0d %0d", peak_bin, peak_val, exp_pk_bin, exp_pk_val);
    end
    check_results("post_reset");
  endtask

  task automatic test_random();
    int lat;
    bit fl;
    int avs[3] = '{3, 7, 1};
    for (int r = 0; r < 3; r++) begin
      fill_random();
      model(avs[r]);
      run_capture(avs[r], (r == 2) ? 20 : 0, 0, lat, fl);
      n_checks++;
      if (lat != 4) begin
        n_fail++;
        $display("FAIL random%0d_latency: got %0d required 4", r, lat);
      end
      n_checks++;
      if (peak_bin !== LOG2N'(exp_pk_bin) || peak_val !== PW'(exp_pk_val)) begin
        n_fail++;
        $display("FAIL random%0d_peak: got bin %0d val %0d required %0d %0d", r, peak_bin, peak_val, exp_pk_bin, exp_pk_val);
      end
      check_results("random");
    end
  endtask

  initial begin
    repeat (2) @(posedge clk_Cal);
    #1;
    test_reset();
    @(negedge clk_Cal);
    rst_n = 1;
    test_ramp();
    test_avg4();
    test_gaps();
    test_tlast();
    test_ties();
    test_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
